// File: rtl/leaf_pkg.sv
// Shared types, defaults and slice-offset helper for the leaf port bank.
package leaf_pkg;

  localparam int DEFAULT_PAYLOAD_BITS = 32;
  localparam int DEFAULT_COUNT_BITS   = 16;

  typedef struct packed {
    logic [DEFAULT_PAYLOAD_BITS-1:0] data;
    logic                            vld;
  } leaf_hs_t;

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/leaf_skid_buf.sv
// One channel: 2-entry skid buffer with enable gating, sync clear and a saturating beat counter.
module leaf_skid_buf
  import leaf_pkg::*;
#(
  parameter int PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS,
  parameter int COUNT_BITS   = DEFAULT_COUNT_BITS
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    en,
  input  logic [PAYLOAD_BITS-1:0] up_data,
  input  logic                    up_vld,
  output logic                    up_ack,
  output logic [PAYLOAD_BITS-1:0] dn_data,
  output logic                    dn_vld,
  input  logic                    dn_ack,
  output logic [COUNT_BITS-1:0]   count
);

  logic [1:0]              occ_q, occ_d;
  logic [PAYLOAD_BITS-1:0] head_q, head_d;
  logic [PAYLOAD_BITS-1:0] tail_q, tail_d;
  logic [COUNT_BITS-1:0]   count_q, count_d;
  logic                    ready_q;
  logic                    push;
  logic                    pop;

  // ready_q holds ack low until the first edge after reset release.
  assign up_ack  = ready_q & (occ_q != 2'd2) & en & ~clear;
  assign dn_vld  = (occ_q != 2'd0) & en;
  assign dn_data = head_q;
  assign count   = count_q;
  assign push    = up_vld & up_ack;
  assign pop     = dn_vld & dn_ack;

  // Next-state: unused entries are kept at zero so the head is 0 when empty.
  always_comb begin
    occ_d   = occ_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      occ_d   = 2'd0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_d = up_data;
          end else begin
            tail_d = up_data;
          end
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          tail_d = '0;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_d = up_data;
          end else begin
            head_d = tail_q;
            tail_d = up_data;
          end
        end
        default: begin
          occ_d = occ_q;
        end
      endcase
      if (pop && (count_q != {COUNT_BITS{1'b1}})) begin
        count_d = count_q + COUNT_BITS'(1);
      end else begin
        count_d = count_q;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q   <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ready_q <= 1'b1;
    end
  end

endmodule

// File: rtl/leaf_port_bank.sv
// User-side port bank: one skid-buffered channel per input and output port.
module leaf_port_bank
  import leaf_pkg::*;
#(
  parameter int NUM_IN_PORTS  = 4,
  parameter int NUM_OUT_PORTS = 7,
  parameter int PAYLOAD_BITS  = DEFAULT_PAYLOAD_BITS,
  parameter int COUNT_BITS    = DEFAULT_COUNT_BITS
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  clear,
  input  logic [NUM_IN_PORTS-1:0]               in_en_mask,
  input  logic [NUM_OUT_PORTS-1:0]              out_en_mask,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user,
  input  logic [NUM_IN_PORTS-1:0]               vld_interface2user,
  output logic [NUM_IN_PORTS-1:0]               ack_user2interface,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_bank2user,
  output logic [NUM_IN_PORTS-1:0]               vld_bank2user,
  input  logic [NUM_IN_PORTS-1:0]               ack_user2bank,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user2bank,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2bank,
  output logic [NUM_OUT_PORTS-1:0]              ack_bank2user,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  output logic [NUM_IN_PORTS*COUNT_BITS-1:0]    in_count,
  output logic [NUM_OUT_PORTS*COUNT_BITS-1:0]   out_count
);

  for (genvar k = 0; k < NUM_IN_PORTS; k++) begin : g_in
    localparam int DLO = slice_lo(k, PAYLOAD_BITS);
    localparam int CLO = slice_lo(k, COUNT_BITS);
    leaf_skid_buf #(
      .PAYLOAD_BITS(PAYLOAD_BITS),
      .COUNT_BITS  (COUNT_BITS)
    ) u_buf (
      .clk    (clk),
      .reset_n(reset_n),
      .clear  (clear),
      .en     (in_en_mask[k]),
      .up_data(dout_leaf_interface2user[DLO +: PAYLOAD_BITS]),
      .up_vld (vld_interface2user[k]),
      .up_ack (ack_user2interface[k]),
      .dn_data(dout_bank2user[DLO +: PAYLOAD_BITS]),
      .dn_vld (vld_bank2user[k]),
      .dn_ack (ack_user2bank[k]),
      .count  (in_count[CLO +: COUNT_BITS])
    );
  end

  for (genvar k = 0; k < NUM_OUT_PORTS; k++) begin : g_out
    localparam int DLO = slice_lo(k, PAYLOAD_BITS);
    localparam int CLO = slice_lo(k, COUNT_BITS);
    leaf_skid_buf #(
      .PAYLOAD_BITS(PAYLOAD_BITS),
      .COUNT_BITS  (COUNT_BITS)
    ) u_buf (
      .clk    (clk),
      .reset_n(reset_n),
      .clear  (clear),
      .en     (out_en_mask[k]),
      .up_data(din_user2bank[DLO +: PAYLOAD_BITS]),
      .up_vld (vld_user2bank[k]),
      .up_ack (ack_bank2user[k]),
      .dn_data(din_leaf_user2interface[DLO +: PAYLOAD_BITS]),
      .dn_vld (vld_user2interface[k]),
      .dn_ack (ack_interface2user[k]),
      .count  (out_count[CLO +: COUNT_BITS])
    );
  end

endmodule

// File: tb/tb_leaf_port_bank.sv
// Directed bench for leaf_port_bank; a second copy with 4-bit counters shares the stimulus.
module tb_leaf_port_bank;

  localparam int NI = 4;
  localparam int NO = 7;
  localparam int PB = 32;
  localparam int CB = 16;
  localparam int CB4 = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic clear;
  logic [NI-1:0]    in_en_mask;
  logic [NO-1:0]    out_en_mask;
  logic [NI*PB-1:0] dout_leaf_interface2user;
  logic [NI-1:0]    vld_interface2user;
  logic [NI-1:0]    ack_user2bank;
  logic [NO*PB-1:0] din_user2bank;
  logic [NO-1:0]    vld_user2bank;
  logic [NO-1:0]    ack_interface2user;

  logic [NI-1:0]    ack_user2interface, ack_user2interface_4;
  logic [NI*PB-1:0] dout_bank2user, dout_bank2user_4;
  logic [NI-1:0]    vld_bank2user, vld_bank2user_4;
  logic [NO-1:0]    ack_bank2user, ack_bank2user_4;
  logic [NO*PB-1:0] din_leaf_user2interface, din_leaf_user2interface_4;
  logic [NO-1:0]    vld_user2interface, vld_user2interface_4;
  logic [NI*CB-1:0] in_count;
  logic [NO*CB-1:0] out_count;
  logic [NI*CB4-1:0] in_count_4;
  logic [NO*CB4-1:0] out_count_4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  leaf_port_bank #(.NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO), .PAYLOAD_BITS(PB), .COUNT_BITS(CB)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_en_mask(in_en_mask), .out_en_mask(out_en_mask),
    .dout_leaf_interface2user(dout_leaf_interface2user), .vld_interface2user(vld_interface2user),
    .ack_user2interface(ack_user2interface), .dout_bank2user(dout_bank2user),
    .vld_bank2user(vld_bank2user), .ack_user2bank(ack_user2bank),
    .din_user2bank(din_user2bank), .vld_user2bank(vld_user2bank), .ack_bank2user(ack_bank2user),
    .din_leaf_user2interface(din_leaf_user2interface), .vld_user2interface(vld_user2interface),
    .ack_interface2user(ack_interface2user), .in_count(in_count), .out_count(out_count)
  );

  leaf_port_bank #(.NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO), .PAYLOAD_BITS(PB), .COUNT_BITS(CB4)) dut4 (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_en_mask(in_en_mask), .out_en_mask(out_en_mask),
    .dout_leaf_interface2user(dout_leaf_interface2user), .vld_interface2user(vld_interface2user),
    .ack_user2interface(ack_user2interface_4), .dout_bank2user(dout_bank2user_4),
    .vld_bank2user(vld_bank2user_4), .ack_user2bank(ack_user2bank),
    .din_user2bank(din_user2bank), .vld_user2bank(vld_user2bank), .ack_bank2user(ack_bank2user_4),
    .din_leaf_user2interface(din_leaf_user2interface_4), .vld_user2interface(vld_user2interface_4),
    .ack_interface2user(ack_interface2user), .in_count(in_count_4), .out_count(out_count_4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear = 1'b0;
    in_en_mask = '1;
    out_en_mask = '1;
    vld_interface2user = '1;
    ack_user2bank = '1;
    vld_user2bank = '1;
    ack_interface2user = '1;
    dout_leaf_interface2user = {NI{32'h1234_5678}};
    din_user2bank = {NO{32'h8765_4321}};
    repeat (3) step();
    checks++;
    if (ack_user2interface !== 4'h0 || ack_bank2user !== 7'h00) begin
      errors++;
      $display("FAIL reset_ack: got in=%h out=%h want 0", ack_user2interface, ack_bank2user);
    end
    checks++;
    if (vld_bank2user !== 4'h0 || vld_user2interface !== 7'h00) begin
      errors++;
      $display("FAIL reset_vld: got in=%h out=%h want 0", vld_bank2user, vld_user2interface);
    end
    checks++;
    if (dout_bank2user !== '0 || din_leaf_user2interface !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h / %h want 0", dout_bank2user, din_leaf_user2interface);
    end
    checks++;
    if (in_count !== '0 || out_count !== '0) begin
      errors++;
      $display("FAIL reset_count: got %h / %h want 0", in_count, out_count);
    end
    vld_interface2user = '0;
    vld_user2bank = '0;
    reset_n = 1'b1;
    #1;
    checks++;
    if (ack_user2interface !== 4'h0 || ack_bank2user !== 7'h00) begin
      errors++;
      $display("FAIL release_ack_early: got in=%h out=%h want 0", ack_user2interface, ack_bank2user);
    end
    step();
    checks++;
    if (ack_user2interface !== 4'hF || ack_bank2user !== 7'h7F ||
        ack_user2interface_4 !== 4'hF || ack_bank2user_4 !== 7'h7F) begin
      errors++;
      $display("FAIL release_ack: got in=%h out=%h (cb4 %h %h) want all ones",
               ack_user2interface, ack_bank2user, ack_user2interface_4, ack_bank2user_4);
    end
  endtask

  task automatic test_single_beat();
    step();
    ack_user2bank = '0;
    dout_leaf_interface2user[0 +: PB] = 32'hDEAD_BEEF;
    vld_interface2user[0] = 1'b1;
    @(posedge clk);
    #1;
    vld_interface2user[0] = 1'b0;
    #1;
    checks++;
    if (vld_bank2user[0] !== 1'b1 || dout_bank2user[0 +: PB] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_beat: got vld=%b data=%h want 1 deadbeef", vld_bank2user[0], dout_bank2user[0 +: PB]);
    end
    checks++;
    if (in_count[0 +: CB] !== 16'd0) begin
      errors++;
      $display("FAIL single_count_pre: got %0d want 0", in_count[0 +: CB]);
    end
    ack_user2bank[0] = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if (vld_bank2user[0] !== 1'b0 || in_count[0 +: CB] !== 16'd1 || dout_bank2user[0 +: PB] !== 32'h0) begin
      errors++;
      $display("FAIL single_after_ack: got vld=%b cnt=%0d data=%h want 0 1 0",
               vld_bank2user[0], in_count[0 +: CB], dout_bank2user[0 +: PB]);
    end
    ack_user2bank[0] = 1'b0;
  endtask

  task automatic test_backpressure();
    int sent, rcv, cyc;
    logic ackb, px, cx;
    sent = 0;
    rcv = 0;
    cyc = 0;
    step();
    while (rcv < 100 && cyc < 1000) begin
      ackb = 1'($urandom_range(0, 1));
      ack_interface2user[6] = ackb;
      vld_user2bank[6] = (sent < 100);
      din_user2bank[6*PB +: PB] = 32'h0000_1000 + 32'(sent);
      #1;
      checks++;
      if (vld_user2interface[6] !== (sent != rcv)) begin
        errors++;
        $display("FAIL bp_vld cyc=%0d: got %b want %b", cyc, vld_user2interface[6], (sent != rcv));
      end
      checks++;
      if (ack_bank2user[6] !== ((sent - rcv) < 2)) begin
        errors++;
        $display("FAIL bp_ack cyc=%0d: got %b want %b", cyc, ack_bank2user[6], ((sent - rcv) < 2));
      end
      px = vld_user2bank[6] & ack_bank2user[6];
      cx = vld_user2interface[6] & ackb;
      if (cx) begin
        checks++;
        if (din_leaf_user2interface[6*PB +: PB] !== 32'h0000_1000 + 32'(rcv)) begin
          errors++;
          $display("FAIL bp_data beat=%0d: got %h want %h", rcv,
                   din_leaf_user2interface[6*PB +: PB], 32'h0000_1000 + 32'(rcv));
        end
      end
      @(posedge clk);
      #1;
      if (px) sent++;
      if (cx) rcv++;
      cyc++;
    end
    vld_user2bank[6] = 1'b0;
    ack_interface2user[6] = 1'b0;
    checks++;
    if (rcv != 100) begin
      errors++;
      $display("FAIL bp_timeout: got %0d beats want 100", rcv);
    end
    #1;
    checks++;
    if (out_count[6*CB +: CB] !== 16'd100) begin
      errors++;
      $display("FAIL bp_count: got %0d want 100", out_count[6*CB +: CB]);
    end
  endtask

  task automatic test_mask();
    step();
    ack_interface2user[2] = 1'b0;
    vld_user2bank[2] = 1'b1;
    din_user2bank[2*PB +: PB] = 32'hA2A2_0001;
    step();
    din_user2bank[2*PB +: PB] = 32'hA2A2_0002;
    step();
    din_user2bank[2*PB +: PB] = 32'hA2A2_0003;
    out_en_mask[2] = 1'b0;
    ack_interface2user[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (vld_user2interface[2] !== 1'b0 || ack_bank2user[2] !== 1'b0) begin
        errors++;
        $display("FAIL mask_hold i=%0d: got vld=%b ack=%b want 0 0", i, vld_user2interface[2], ack_bank2user[2]);
      end
      @(posedge clk);
      #1;
    end
    out_en_mask[2] = 1'b1;
    #1;
    checks++;
    if (vld_user2interface[2] !== 1'b1 || din_leaf_user2interface[2*PB +: PB] !== 32'hA2A2_0001 ||
        ack_bank2user[2] !== 1'b0) begin
      errors++;
      $display("FAIL mask_beat1: got vld=%b data=%h ack=%b want 1 a2a20001 0",
               vld_user2interface[2], din_leaf_user2interface[2*PB +: PB], ack_bank2user[2]);
    end
    @(posedge clk);
    #2;
    checks++;
    if (vld_user2interface[2] !== 1'b1 || din_leaf_user2interface[2*PB +: PB] !== 32'hA2A2_0002 ||
        ack_bank2user[2] !== 1'b1) begin
      errors++;
      $display("FAIL mask_beat2: got vld=%b data=%h ack=%b want 1 a2a20002 1",
               vld_user2interface[2], din_leaf_user2interface[2*PB +: PB], ack_bank2user[2]);
    end
    @(posedge clk);
    #1;
    vld_user2bank[2] = 1'b0;
    #1;
    checks++;
    if (vld_user2interface[2] !== 1'b1 || din_leaf_user2interface[2*PB +: PB] !== 32'hA2A2_0003) begin
      errors++;
      $display("FAIL mask_beat3: got vld=%b data=%h want 1 a2a20003",
               vld_user2interface[2], din_leaf_user2interface[2*PB +: PB]);
    end
    @(posedge clk);
    #2;
    checks++;
    if (vld_user2interface[2] !== 1'b0 || out_count[2*CB +: CB] !== 16'd3) begin
      errors++;
      $display("FAIL mask_done: got vld=%b cnt=%0d want 0 3", vld_user2interface[2], out_count[2*CB +: CB]);
    end
  endtask

  task automatic test_clear();
    step();
    ack_user2bank = '0;
    ack_interface2user = '0;
    vld_interface2user[1] = 1'b1;
    dout_leaf_interface2user[1*PB +: PB] = 32'h1111_0001;
    vld_user2bank[0] = 1'b1;
    din_user2bank[0 +: PB] = 32'h0000_C0DE;
    step();
    dout_leaf_interface2user[1*PB +: PB] = 32'h1111_0002;
    clear = 1'b1;
    #1;
    checks++;
    if (vld_bank2user[1] !== 1'b1 || vld_user2interface[0] !== 1'b1) begin
      errors++;
      $display("FAIL clear_precond: got in_vld=%b out_vld=%b want 1 1", vld_bank2user[1], vld_user2interface[0]);
    end
    checks++;
    if (ack_user2interface !== 4'h0 || ack_bank2user !== 7'h00 || ack_user2interface_4 !== 4'h0) begin
      errors++;
      $display("FAIL clear_ack: got in=%h out=%h want 0", ack_user2interface, ack_bank2user);
    end
    @(posedge clk);
    #1;
    clear = 1'b0;
    vld_interface2user = '0;
    vld_user2bank = '0;
    #1;
    checks++;
    if (vld_bank2user !== 4'h0 || vld_user2interface !== 7'h00 ||
        dout_bank2user !== '0 || din_leaf_user2interface !== '0) begin
      errors++;
      $display("FAIL clear_flush: got vld %h %h data %h %h want 0",
               vld_bank2user, vld_user2interface, dout_bank2user, din_leaf_user2interface);
    end
    checks++;
    if (in_count !== '0 || out_count !== '0) begin
      errors++;
      $display("FAIL clear_count: got %h / %h want 0", in_count, out_count);
    end
    checks++;
    if (vld_bank2user_4 !== 4'h0 || vld_user2interface_4 !== 7'h00 || dout_bank2user_4 !== '0 ||
        din_leaf_user2interface_4 !== '0 || in_count_4 !== '0 || out_count_4 !== '0 ||
        ack_bank2user_4 !== 7'h7F) begin
      errors++;
      $display("FAIL clear_cb4: got vld %h %h cnt %h %h ack %h want 0 0 0 0 7f",
               vld_bank2user_4, vld_user2interface_4, in_count_4, out_count_4, ack_bank2user_4);
    end
    ack_user2bank = '1;
    step();
    checks++;
    if (vld_bank2user !== 4'h0 || in_count !== '0) begin
      errors++;
      $display("FAIL clear_stale: got vld=%h cnt=%h want 0", vld_bank2user, in_count);
    end
  endtask

  task automatic test_saturation();
    int sent, rcv, cyc;
    logic px, cx;
    sent = 0;
    rcv = 0;
    cyc = 0;
    step();
    ack_user2bank[3] = 1'b1;
    while (rcv < 20 && cyc < 200) begin
      vld_interface2user[3] = (sent < 20);
      dout_leaf_interface2user[3*PB +: PB] = 32'h0000_0300 + 32'(sent);
      #1;
      px = vld_interface2user[3] & ack_user2interface[3];
      cx = vld_bank2user[3] & ack_user2bank[3];
      if (cx) begin
        checks++;
        if (dout_bank2user[3*PB +: PB] !== 32'h0000_0300 + 32'(rcv) ||
            dout_bank2user_4[3*PB +: PB] !== 32'h0000_0300 + 32'(rcv)) begin
          errors++;
          $display("FAIL sat_data beat=%0d: got %h / %h want %h", rcv, dout_bank2user[3*PB +: PB],
                   dout_bank2user_4[3*PB +: PB], 32'h0000_0300 + 32'(rcv));
        end
      end
      @(posedge clk);
      #1;
      if (px) sent++;
      if (cx) rcv++;
      cyc++;
    end
    vld_interface2user[3] = 1'b0;
    checks++;
    if (rcv != 20) begin
      errors++;
      $display("FAIL sat_timeout: got %0d beats want 20", rcv);
    end
    #1;
    checks++;
    if (in_count_4[3*CB4 +: CB4] !== 4'hF) begin
      errors++;
      $display("FAIL sat_count4: got %0d want 15", in_count_4[3*CB4 +: CB4]);
    end
    checks++;
    if (in_count[3*CB +: CB] !== 16'd20) begin
      errors++;
      $display("FAIL sat_count16: got %0d want 20", in_count[3*CB +: CB]);
    end
  endtask

  task automatic test_reset_midstream();
    step();
    ack_interface2user[6] = 1'b0;
    vld_user2bank[6] = 1'b1;
    din_user2bank[6*PB +: PB] = 32'hAAAA_0001;
    step();
    din_user2bank[6*PB +: PB] = 32'hAAAA_0002;
    step();
    checks++;
    if (vld_user2interface[6] !== 1'b1 || ack_bank2user[6] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_precond: got vld=%b ack=%b want 1 0", vld_user2interface[6], ack_bank2user[6]);
    end
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (vld_user2interface !== 7'h00 || ack_bank2user !== 7'h00 ||
        vld_bank2user !== 4'h0 || ack_user2interface !== 4'h0) begin
      errors++;
      $display("FAIL midrst_drop: got vld %h %h ack %h %h want 0",
               vld_user2interface, vld_bank2user, ack_bank2user, ack_user2interface);
    end
    checks++;
    if (in_count !== '0 || out_count !== '0 || din_leaf_user2interface !== '0) begin
      errors++;
      $display("FAIL midrst_state: got cnt %h %h data %h want 0", in_count, out_count, din_leaf_user2interface);
    end
    vld_user2bank = '0;
    ack_interface2user = '1;
    ack_user2bank = '1;
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (vld_user2interface !== 7'h00 || vld_bank2user !== 4'h0) begin
        errors++;
        $display("FAIL midrst_stale i=%0d: got %h %h want 0", i, vld_user2interface, vld_bank2user);
      end
      step();
    end
    checks++;
    if (ack_bank2user !== 7'h7F || ack_user2interface !== 4'hF) begin
      errors++;
      $display("FAIL midrst_ack: got %h %h want 7f f", ack_bank2user, ack_user2interface);
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_backpressure();
    test_mask();
    test_clear();
    test_saturation();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
